// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 device-side model; oversamples STB/SCLK/DIO, decodes commands into a 16-byte display RAM,
// and shifts a 32-bit key snapshot out on read commands.
module tm1638_responder #(
  parameter int C_SYNC = 2
) (
  input  logic         CK_i,
  input  logic         ARST_i,
  input  logic         STB_i,
  input  logic         SCLK_i,
  input  logic         DIO_i,
  output logic         DIO_o,
  output logic         DIO_OE_o,
  input  logic [31:0]  KEYS_DAT_i,
  output logic [127:0] DISP_RAM_o,
  output logic         DISP_ON_o,
  output logic [2:0]   BRIGHT_o,
  output logic         FRAME_DONE_o,
  output logic         BUSY_o
);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;
  state_t r_state, w_next;
  logic [C_SYNC-1:0][2:0] r_sync;
  logic [1:0] r_hist;
  logic [2:0] w_in;
  logic w_stb, w_sclk, w_dio, w_stb_rise, w_stb_fall, w_sclk_rise, w_sclk_fall, w_done, w_cmd_done;
  logic [6:0] r_sr;
  logic [7:0] w_byte;
  logic [2:0] r_bitcnt;
  logic [3:0] r_addr;
  logic [31:0] r_tx;
  logic r_read, r_fixed, r_wrote;
  assign w_in = r_sync[C_SYNC-1];
  assign {w_stb, w_sclk, w_dio} = w_in;
  assign w_stb_rise = w_stb & ~r_hist[1];
  assign w_stb_fall = ~w_stb & r_hist[1];
  assign w_sclk_rise = w_sclk & ~r_hist[0] & ~w_stb;
  assign w_sclk_fall = ~w_sclk & r_hist[0] & ~w_stb;
  assign w_byte = {w_dio, r_sr};
  assign w_done = w_sclk_rise & (r_bitcnt == 3'd7);
  assign w_cmd_done = w_done & (r_state == CMD);
  assign BUSY_o = ~w_stb;
  always_comb begin
    w_next = r_state;
    if (w_stb_rise) w_next = IDLE;
    else if (w_stb_fall) w_next = CMD;
    else if (w_cmd_done)
      w_next = (w_byte[7:6] == 2'b01 && w_byte[1]) ? RDATA :
               (w_byte[7:6] == 2'b11 && !r_read) ? WDATA : IGNORE;
  end
  always_ff @(posedge CK_i or posedge ARST_i)
    if (ARST_i) r_state <= IDLE;
    else r_state <= w_next;
  // Sync chain resets to the idle line levels so no false edge follows reset release
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_sync <= '1;
      r_hist <= '1;
      r_sr <= '0;
      r_bitcnt <= '0;
      r_addr <= '0;
      r_tx <= '0;
      r_read <= 1'b0;
      r_fixed <= 1'b0;
      r_wrote <= 1'b0;
      DIO_o <= 1'b1;
      DIO_OE_o <= 1'b0;
      DISP_RAM_o <= '0;
      DISP_ON_o <= 1'b0;
      BRIGHT_o <= '0;
      FRAME_DONE_o <= 1'b0;
    end else begin
      r_sync <= {r_sync[C_SYNC-2:0], {STB_i, SCLK_i, DIO_i}};
      r_hist <= w_in[2:1];
      FRAME_DONE_o <= w_stb_rise & r_wrote;
      if (w_stb_fall) begin
        r_bitcnt <= '0;
        r_wrote <= 1'b0;
      end else if (w_sclk_rise) begin
        r_sr <= w_byte[7:1];
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_stb_rise) begin
        DIO_OE_o <= 1'b0;
        DIO_o <= 1'b1;
        r_wrote <= 1'b0;
      end else if (w_cmd_done) begin
        if (w_byte[7:6] == 2'b01) begin
          r_read <= w_byte[1];
          r_fixed <= w_byte[2];
          if (w_byte[1]) begin
            r_tx <= KEYS_DAT_i;
            DIO_OE_o <= 1'b1;
          end
        end
        if (w_byte[7:6] == 2'b11) r_addr <= w_byte[3:0];
        if (w_byte[7:6] == 2'b10) begin
          DISP_ON_o <= w_byte[3];
          BRIGHT_o <= w_byte[2:0];
        end
      end else if (w_done && r_state == WDATA) begin
        DISP_RAM_o[{r_addr, 3'b000} +: 8] <= w_byte;
        r_wrote <= 1'b1;
        if (!r_fixed) r_addr <= r_addr + 4'd1;
      end else if (w_sclk_fall && r_state == RDATA) begin
        // Zero-fill makes every bit past the fourth key byte read as 0
        DIO_o <= r_tx[0];
        r_tx <= {1'b0, r_tx[31:1]};
      end
    end
  end
endmodule

// File: tb/tb_tm1638_responder.sv
// tb_tm1638_responder: directed and randomized transactions against a byte-level reference model.
module tb_tm1638_responder;
  localparam int H = 6;
  logic CK_i = 0, ARST_i = 1, STB_i = 1, SCLK_i = 1, DIO_i = 1;
  logic [31:0] KEYS_DAT_i = '0;
  logic DIO_o, DIO_OE_o, DISP_ON_o, FRAME_DONE_o, BUSY_o;
  logic [127:0] DISP_RAM_o;
  logic [2:0] BRIGHT_o;
  int checks = 0, failures = 0, fd_cnt = 0;
  logic [7:0] m_ram[16];
  logic m_on = 0, m_read = 0, m_fixed = 0;
  logic [2:0] m_br = 0;
  int m_addr = 0;
  logic [31:0] m_keys;
  logic [7:0] tx_q[$];
  tm1638_responder #(.C_SYNC(2)) dut (
    .CK_i(CK_i), .ARST_i(ARST_i), .STB_i(STB_i), .SCLK_i(SCLK_i), .DIO_i(DIO_i),
    .DIO_o(DIO_o), .DIO_OE_o(DIO_OE_o), .KEYS_DAT_i(KEYS_DAT_i), .DISP_RAM_o(DISP_RAM_o),
    .DISP_ON_o(DISP_ON_o), .BRIGHT_o(BRIGHT_o), .FRAME_DONE_o(FRAME_DONE_o), .BUSY_o(BUSY_o)
  );
  always #5 CK_i = ~CK_i;
  always @(negedge CK_i) if (FRAME_DONE_o) fd_cnt++;
  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] ram_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_ram[i];
    return v;
  endfunction
  task automatic cyc(int n);
    repeat (n) @(posedge CK_i);
    #1;
  endtask
  task automatic put(int n, logic [7:0] a = 0, logic [7:0] b = 0, logic [7:0] c = 0);
    tx_q.delete();
    if (n > 0) tx_q.push_back(a);
    if (n > 1) tx_q.push_back(b);
    if (n > 2) tx_q.push_back(c);
  endtask
  task automatic send_bits(logic [7:0] b, int n);
    for (int i = 0; i < n; i++) begin
      SCLK_i = 0;
      DIO_i = b[i];
      cyc(H);
      SCLK_i = 1;
      cyc(H);
    end
    DIO_i = 1;
  endtask
  task automatic wr_txn(string tag, int partial = 0);
    int fd0;
    logic wrote;
    logic [7:0] c;
    fd0 = fd_cnt;
    wrote = 0;
    STB_i = 0;
    cyc(H);
    check({tag, " busy"}, BUSY_o, 1);
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    if (partial > 0) send_bits(8'($urandom), partial);
    cyc(H);
    STB_i = 1;
    cyc(H);
    if (tx_q.size() > 0) begin
      c = tx_q[0];
      if (c[7:6] == 2'b01) begin
        m_read = c[1];
        m_fixed = c[2];
      end else if (c[7:6] == 2'b10) begin
        m_on = c[3];
        m_br = c[2:0];
      end else if (c[7:6] == 2'b11) begin
        m_addr = int'(c[3:0]);
        if (!m_read)
          for (int i = 1; i < tx_q.size(); i++) begin
            m_ram[m_addr] = tx_q[i];
            wrote = 1;
            if (!m_fixed) m_addr = (m_addr + 1) % 16;
          end
      end
    end
    check({tag, " ram"}, DISP_RAM_o, ram_vec());
    check({tag, " on"}, DISP_ON_o, m_on);
    check({tag, " bright"}, BRIGHT_o, m_br);
    check({tag, " frame"}, fd_cnt - fd0, wrote);
  endtask
  task automatic rd_txn(string tag, logic [7:0] cmd, int nbytes);
    int fd0;
    logic [7:0] got;
    logic [31:0] exp;
    fd0 = fd_cnt;
    KEYS_DAT_i = m_keys;
    exp = m_keys;
    STB_i = 0;
    cyc(H);
    send_bits(cmd, 8);
    m_read = cmd[1];
    m_fixed = cmd[2];
    KEYS_DAT_i = $urandom;
    check({tag, " oe_on"}, DIO_OE_o, 1);
    for (int b = 0; b < nbytes; b++) begin
      got = 0;
      for (int i = 0; i < 8; i++) begin
        SCLK_i = 0;
        cyc(H);
        got[i] = DIO_o;
        SCLK_i = 1;
        cyc(H);
      end
      check($sformatf("%s byte%0d", tag, b), got, b < 4 ? exp[b*8 +: 8] : 8'h00);
    end
    check({tag, " oe_hold"}, DIO_OE_o, 1);
    cyc(H);
    STB_i = 1;
    cyc(H);
    check({tag, " oe_off"}, DIO_OE_o, 0);
    check({tag, " dio_idle"}, DIO_o, 1);
    check({tag, " frame"}, fd_cnt - fd0, 0);
    check({tag, " ram"}, DISP_RAM_o, ram_vec());
  endtask
  initial begin
    int k;
    logic [7:0] c;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    cyc(3);
    check("rst ram", DISP_RAM_o, 0);
    check("rst outs", {DIO_o, DIO_OE_o, DISP_ON_o, BRIGHT_o, FRAME_DONE_o, BUSY_o}, 8'b1000_0000);
    ARST_i = 0;
    cyc(4);
    put(1, 8'h40);
    wr_txn("auto cmd");
    tx_q.delete();
    tx_q.push_back(8'hC0);
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    wr_txn("auto data");
    put(1, 8'h44);
    wr_txn("fix cmd");
    put(2, 8'hC5, 8'hAA);
    wr_txn("fix aa");
    put(3, 8'hC5, 8'h11, 8'h22);
    wr_txn("fix 22");
    put(1, 8'h40);
    wr_txn("wrap cmd");
    put(3, 8'hCF, 8'h33, 8'h44);
    wr_txn("wrap data");
    put(1, 8'h8C);
    wr_txn("disp on");
    put(1, 8'h80);
    wr_txn("disp off");
    m_keys = 32'h12345678;
    rd_txn("keys", 8'h42, 5);
    put(1, 8'h40);
    wr_txn("abort cmd");
    put(1, 8'hC0);
    wr_txn("abort", 4);
    put(2, 8'hC3, 8'h5A);
    wr_txn("after abort");
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 4);
      c = 8'($urandom);
      if (k == 0) begin
        put(1, {2'b01, c[5:2], 1'b0, c[0]});
        wr_txn("r datacmd", $urandom_range(0, 1) ? 0 : $urandom_range(1, 7));
      end else if (k == 1) begin
        put(1, {2'b11, c[5:0]});
        for (int i = $urandom_range(0, 5); i > 0; i--) tx_q.push_back(8'($urandom));
        wr_txn("r write", $urandom_range(0, 1) ? 0 : $urandom_range(1, 7));
      end else if (k == 2) begin
        put(1, {2'b10, c[5:0]});
        wr_txn("r disp");
      end else if (k == 3) begin
        m_keys = $urandom;
        rd_txn("r read", {2'b01, c[5:2], 1'b1, c[0]}, $urandom_range(1, 5));
      end else begin
        put(2, {2'b00, c[5:0]}, 8'($urandom));
        wr_txn("r junk");
      end
    end
    STB_i = 0;
    cyc(H);
    send_bits(8'h42, 8);
    send_bits(8'h00, 3);
    #2 ARST_i = 1;
    #1;
    check("arst ram", DISP_RAM_o, 0);
    check("arst outs", {DIO_o, DIO_OE_o, DISP_ON_o, BRIGHT_o, FRAME_DONE_o, BUSY_o}, 8'b1000_0000);
    STB_i = 1;
    SCLK_i = 1;
    cyc(2);
    ARST_i = 0;
    for (int i = 0; i < 16; i++) m_ram[i] = 0;
    m_on = 0;
    m_br = 0;
    m_read = 0;
    m_fixed = 0;
    m_addr = 0;
    cyc(H);
    check("post rst ram", DISP_RAM_o, 0);
    put(2, 8'hC7, 8'h9E);
    wr_txn("post rst write");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
Synchronous model of the TM1638 device side of the STB/CLK/DIO link. It oversamples the serial lines in the CK_i domain and decodes data, address and display-control commands into a 16-byte display RAM. It returns a 32-bit key snapshot on read commands. Uses: a board-less loopback target for the LED/KEY driver, and a TM1638 emulator on a second FPGA.

Parameters:
C_SYNC, 2, synchronizer depth on STB_i, SCLK_i and DIO_i (min 2).

Ports:
CK_i  in  1  system clock, rising edge.
ARST_i  in  1  reset, asynchronous, active-high.
STB_i  in  1  strobe, active low.
SCLK_i  in  1  serial clock, idle high.
DIO_i  in  1  serial data from the controller.
DIO_o  out  1  serial read data.
DIO_OE_o  out  1  drive enable for DIO_o.
KEYS_DAT_i  in  32  key bytes; byte n = bits [8n+7:8n], sent n=0..3.
DISP_RAM_o  out  128  display RAM; address a = bits [8a+7:8a].
DISP_ON_o  out  1  display-on flag.
BRIGHT_o  out  3  brightness code.
FRAME_DONE_o  out  1  1-cycle pulse; STB rose after at least one RAM byte was written in that transaction.
BUSY_o  out  1  high while synchronized STB is low.

Behaviour:
- Reset values: RAM all 0x00, DISP_ON_o=0, BRIGHT_o=0, DIO_o=1, DIO_OE_o=0, FRAME_DONE_o=0, BUSY_o=0. Internal: read_mode=0, fixed_mode=0, addr=0, state IDLE.
- Sync: each input passes through C_SYNC flops, plus one history flop for edge detection. All decisions use the synced values.
- Line timing requirement: SCLK high and low phases each last at least C_SYNC+2 CK cycles.
- Bit framing: data is LSB first. A bit is taken on each synced SCLK rising edge while STB is low: sr <= {DIO, sr[7:1]}, bitcnt++. The 8th bit completes the byte.
- STB falling edge: enter CMD, bitcnt=0, clear wrote flag.
- STB rising edge, from any state:
  - partial byte discarded;
  - DIO_OE_o=0, DIO_o=1;
  - return to IDLE;
  - FRAME_DONE_o pulses on the next cycle if the wrote flag is set.
- States: IDLE, CMD, WDATA, RDATA, IGNORE.
- Byte completed in CMD, decoded on b[7:6]:
  - 01, data command: read_mode=b[1], fixed_mode=b[2]. If b[1]=1, latch KEYS_DAT_i into the tx buffer the same cycle, go RDATA, assert DIO_OE_o. Otherwise go IGNORE.
  - 11, address command: addr=b[3:0]. Go WDATA if read_mode=0, else IGNORE.
  - 10, display control: DISP_ON_o=b[3], BRIGHT_o=b[2:0]; go IGNORE.
  - 00: go IGNORE with no side effects.
- read_mode and fixed_mode persist across transactions until the next data command.
- WDATA: each completed byte writes RAM[addr] and sets the wrote flag. If fixed_mode=0, addr=(addr+1) mod 16 (wraps 15 to 0). If fixed_mode=1, addr is held.
- RDATA, on each synced SCLK falling edge:
  - DIO_o is set to the next tx bit (byte 0 bit 0 first), within C_SYNC+1 cycles of the pin edge.
  - Rising edges only advance bitcnt and the byte index.
  - After 4 bytes, DIO_o=0 for all further bits.
  - DIO_OE_o stays high until STB rises.
- IGNORE: clocks are counted and data is discarded.
- A falling SCLK edge arriving in the same cycle as STB rising is ignored; STB rising has priority.
- RAM updates appear on DISP_RAM_o one cycle after the completing SCLK rising edge is detected.

Test Plan:
1. Reset: assert ARST_i mid-transfer -> all outputs at reset values immediately; RAM reads 0x00 after release.
2. Auto-increment write: txn 0x40; txn 0xC0 + bytes 0x00..0x0F -> RAM[a]=a for all a; FRAME_DONE_o pulses once, only after the second txn.
3. Fixed-address write and wrap:
   - 0x44; 0xC5,0xAA -> only RAM[5]=0xAA;
   - 0xC5,0x11,0x22 -> RAM[5]=0x22;
   - then 0x40; 0xCF,0x33,0x44 -> RAM[15]=0x33, RAM[0]=0x44.
4. Display control: 0x8C -> DISP_ON_o=1, BRIGHT_o=4, RAM unchanged; 0x80 -> DISP_ON_o=0, BRIGHT_o=0.
5. Key read:
   - stimulus: KEYS_DAT_i=0x12345678, txn 0x42 + 40 read clocks;
   - bytes sampled on SCLK rising edges = 0x78,0x56,0x34,0x12,0x00;
   - KEYS_DAT_i changed after the command byte does not affect the data;
   - DIO_OE_o goes high at decode and low at STB rise.
6. Abort: 0x40; then 0xC0 + 4 bits, STB high -> RAM unchanged, no FRAME_DONE_o pulse. A following 0xC3,0x5A txn -> RAM[3]=0x5A.
